// File: rtl/multdiv_unit.sv
// multdiv_unit: multi-cycle signed 32-bit multiply (radix-2 Booth) and
// divide (restoring, on magnitudes) sharing a single adder/subtracter.
// A multiply or divide takes 32 iterations. Every output is registered.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no operation in flight; result/exception held
// MUL   | Booth iteration each cycle, counter 0..31
// DIV   | restoring-division iteration each cycle, counter 0..31
// DONE  | RDY high for one cycle; also entered straight from start on B=0

module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    localparam logic [4:0] LAST_ITER = 5'd31;

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH:0]   b_q, b_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;

    logic             start;
    logic             div_by_zero;
    logic [WIDTH-1:0] abs_a, abs_b;

    logic [WIDTH:0]   add_a, add_b, add_sum;
    logic             add_sub, add_carry;
    logic [WIDTH+1:0] add_full;

    logic             booth_do;
    logic [WIDTH:0]   booth_s, mul_acc_nxt;
    logic [WIDTH-1:0] mul_q_nxt;
    logic [WIDTH:0]   prod_top;
    logic             mul_ovf;

    logic [WIDTH:0]   div_shift, div_acc_nxt;
    logic [WIDTH-1:0] div_q_nxt, quot_signed;
    logic             div_ovf;

    assign start       = ctrl_MULT | ctrl_DIV;
    assign div_by_zero = (data_operandB == '0);

    // 0x80000000 negates to itself, which reads correctly as unsigned 2^31
    assign abs_a = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
    assign abs_b = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;

    // Shared adder/subtracter; subtract is invert-B with carry-in 1, carry = no borrow
    assign add_full  = {1'b0, add_a} + {1'b0, add_b ^ {(WIDTH+1){add_sub}}} + (WIDTH+2)'(add_sub);
    assign add_sum   = add_full[WIDTH:0];
    assign add_carry = add_full[WIDTH+1];

    // Adder operand select: Booth add/sub on the upper word, or division trial subtract
    always_comb begin
        add_a   = acc_q;
        add_b   = b_q;
        add_sub = q_q[0] & ~qm1_q;
        if (state_q == S_DIV) begin
            add_a   = div_shift;
            add_sub = 1'b1;
        end
    end

    // Booth step: optional add/sub, then arithmetic shift right of {acc, q, q_-1}
    always_comb begin
        booth_do    = q_q[0] ^ qm1_q;
        booth_s     = booth_do ? add_sum : acc_q;
        mul_acc_nxt = {booth_s[WIDTH], booth_s[WIDTH:1]};
        mul_q_nxt   = {booth_s[0], q_q[WIDTH-1:1]};
        prod_top    = {mul_acc_nxt[WIDTH-1:0], mul_q_nxt[WIDTH-1]};
        mul_ovf     = ~((&prod_top) | ~(|prod_top));
    end

    // Restoring-division step: shift left, keep trial difference when no borrow
    always_comb begin
        div_shift   = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        div_acc_nxt = add_carry ? add_sum : div_shift;
        div_q_nxt   = {q_q[WIDTH-2:0], add_carry};
        quot_signed = neg_q ? (~div_q_nxt + WIDTH'(1)) : div_q_nxt;
        // only a positive quotient of 2^31 (0x80000000 / -1) is unrepresentable
        div_ovf     = ~neg_q & div_q_nxt[WIDTH-1];
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a start strobe restarts from any state, MULT wins
    always_comb begin
        state_d = state_q;
        if (ctrl_MULT) begin
            state_d = S_MUL;
        end else if (ctrl_DIV) begin
            state_d = div_by_zero ? S_DONE : S_DIV;
        end else begin
            case (state_q)
                S_MUL:   if (cnt_q == LAST_ITER) state_d = S_DONE;
                S_DIV:   if (cnt_q == LAST_ITER) state_d = S_DONE;
                S_DONE:  if (rdy_q) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and registered-output next values
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        q_d      = q_q;
        qm1_d    = qm1_q;
        b_d      = b_q;
        neg_d    = neg_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        busy_d   = busy_q;
        if (start) begin
            cnt_d  = '0;
            acc_d  = '0;
            qm1_d  = 1'b0;
            exc_d  = 1'b0;
            busy_d = 1'b1;
            if (ctrl_MULT) begin
                q_d   = data_operandA;
                b_d   = {data_operandB[WIDTH-1], data_operandB};
                neg_d = 1'b0;
            end else begin
                q_d   = abs_a;
                b_d   = {1'b0, abs_b};
                neg_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            end
        end else begin
            case (state_q)
                S_MUL: begin
                    cnt_d = cnt_q + 5'd1;
                    acc_d = mul_acc_nxt;
                    q_d   = mul_q_nxt;
                    qm1_d = q_q[0];
                    if (cnt_q == LAST_ITER) begin
                        result_d = mul_q_nxt;
                        exc_d    = mul_ovf;
                        rdy_d    = 1'b1;
                        busy_d   = 1'b0;
                    end
                end
                S_DIV: begin
                    cnt_d = cnt_q + 5'd1;
                    acc_d = div_acc_nxt;
                    q_d   = div_q_nxt;
                    if (cnt_q == LAST_ITER) begin
                        result_d = quot_signed;
                        exc_d    = div_ovf;
                        rdy_d    = 1'b1;
                        busy_d   = 1'b0;
                    end
                end
                S_DONE: begin
                    // DONE without a pending pulse means we arrived on divide-by-zero
                    if (!rdy_q) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                        rdy_d    = 1'b1;
                        busy_d   = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            qm1_q    <= qm1_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: directed vectors with hand-computed results for multdiv_unit.

module tb_multdiv_unit;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue a start strobe; returns #1 after the start edge (E0)
    task automatic start_op(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = is_mul;
        ctrl_DIV      = ~is_mul;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    // Count edges after E0 until RDY is seen, bounded at 40
    task automatic wait_rdy(output int cyc);
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clock);
            #1;
            cyc++;
            if (data_resultRDY) break;
        end
    endtask

    task automatic run_op(input string tag, input bit is_mul,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input bit exp_exc, input int exp_lat);
        int cyc;
        start_op(is_mul, a, b);
        chk_eq({tag, " busy@E0"}, 32'(busy), 32'd1);
        chk_eq({tag, " exc_clr@E0"}, 32'(data_exception), 32'd0);
        wait_rdy(cyc);
        chk_eq({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        chk_eq({tag, " result"}, data_result, exp_res);
        chk_eq({tag, " exc"}, 32'(data_exception), 32'(exp_exc));
        chk_eq({tag, " busy@rdy"}, 32'(busy), 32'd0);
        @(posedge clock);
        #1;
        chk_eq({tag, " rdy_width"}, 32'(data_resultRDY), 32'd0);
        chk_eq({tag, " result_hold"}, data_result, exp_res);
        chk_eq({tag, " exc_hold"}, 32'(data_exception), 32'(exp_exc));
    endtask

    initial begin
        int cyc;
        int rdy_seen;
        reset         = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk_eq("rst result", data_result, 32'h0);
        chk_eq("rst exc", 32'(data_exception), 32'd0);
        chk_eq("rst rdy", 32'(data_resultRDY), 32'd0);
        chk_eq("rst busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        run_op("mul 6*-7",        1'b1, 32'd6,        32'hFFFF_FFF9, 32'hFFFF_FFD6, 1'b0, 32);
        run_op("mul 2^16*2^16",   1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 32);
        run_op("mul 8000_0000*1", 1'b1, 32'h8000_0000, 32'd1,        32'h8000_0000, 1'b0, 32);
        run_op("div 100/7",       1'b0, 32'd100,       32'd7,        32'd14,        1'b0, 32);
        run_op("div -100/7",      1'b0, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFF2, 1'b0, 32);
        run_op("div 7/-100",      1'b0, 32'd7,         32'hFFFF_FF9C, 32'h0,        1'b0, 32);
        run_op("div 5/0",         1'b0, 32'd5,         32'h0,        32'h0,         1'b1, 1);
        run_op("div min/-1",      1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32);
        run_op("mul -3*-5",       1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd15,        1'b0, 32);

        // Abort: MULT 3x3, then DIV 20/4 at cycle 10
        rdy_seen = 0;
        start_op(1'b1, 32'd3, 32'd3);
        repeat (9) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_seen++;
        end
        start_op(1'b0, 32'd20, 32'd4);
        wait_rdy(cyc);
        chk_eq("abort no mul rdy", 32'(rdy_seen), 32'd0);
        chk_eq("abort div latency", 32'(cyc), 32'd32);
        chk_eq("abort div result", data_result, 32'd5);
        chk_eq("abort div exc", 32'(data_exception), 32'd0);
        @(posedge clock);
        #1;
        chk_eq("abort rdy width", 32'(data_resultRDY), 32'd0);

        // Reset mid-divide at cycle 15
        start_op(1'b0, 32'd1000, 32'd3);
        repeat (14) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk_eq("midrst busy", 32'(busy), 32'd0);
        chk_eq("midrst rdy", 32'(data_resultRDY), 32'd0);
        chk_eq("midrst result", data_result, 32'h0);
        rdy_seen = 0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_seen++;
        end
        chk_eq("midrst no rdy", 32'(rdy_seen), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        run_op("mul 2*2 post-rst", 1'b1, 32'd2, 32'd2, 32'd4, 1'b0, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
